// File: rtl/clkset_ctl.sv
// Clock-set controller: stages a requested CLK configuration, waits for newly
// enabled oscillator/PLL to settle, commits it, then holds for the clock
// switch to settle before acknowledging. Enables are only ever dropped at the
// commit, so the staged value keeps anything currently running alive.
module clkset_ctl #(
  parameter int OSC_WAIT = 16,
  parameter int PLL_WAIT = 8,
  parameter int SW_HOLD  = 4,
  parameter int CNT_W    = 24
) (
  input  logic       clock_160,
  input  logic       nres,
  input  logic       req,
  input  logic [7:0] req_cfg,
  output logic [7:0] cfg,
  output logic       busy,
  output logic       ack,
  output logic       ign,
  output logic       rst_req
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam int              HOLD_LD = (SW_HOLD > 0) ? SW_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] OSC_CNT  = CNT_W'(OSC_WAIT);
  localparam logic [CNT_W-1:0] PLL_CNT  = CNT_W'(PLL_WAIT);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_LD);

  state_t           state_q, state_d;
  logic [7:0]       cfg_q, cfg_d;
  logic [7:0]       new_q, new_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             ign_q, ign_d;
  logic             rst_q, rst_d;

  logic             osc_new, pll_new;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       staged;

  // Next-state, staged value and settle-count computation
  always_comb begin
    osc_new  = ~cfg_q[5] & req_cfg[5];
    pll_new  = ~cfg_q[6] & req_cfg[6];
    wait_cnt = (osc_new ? OSC_CNT : '0) + (pll_new ? PLL_CNT : '0);
    staged   = {1'b0, cfg_q[6] | req_cfg[6], cfg_q[5] | req_cfg[5],
                osc_new ? req_cfg[4:3] : cfg_q[4:3], cfg_q[2:0]};

    state_d = state_q;
    cfg_d   = cfg_q;
    new_d   = new_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    ign_d   = 1'b0;
    rst_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          new_d   = req_cfg;
          cfg_d   = staged;
          cnt_d   = wait_cnt;
          state_d = WAIT;
        end
      end
      WAIT: begin
        ign_d = req;
        if (cnt_q == '0) begin
          cfg_d   = {1'b0, new_q[6:0]};
          cnt_d   = HOLD_CNT;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        ign_d = req;
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          rst_d   = new_q[7];
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control and committed-configuration registers with synchronous reset
  always_ff @(posedge clock_160) begin
    if (!nres) begin
      state_q <= IDLE;
      cfg_q   <= 8'h00;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      ign_q   <= 1'b0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      ign_q   <= ign_d;
      rst_q   <= rst_d;
    end
  end

  // Latched request value; only consulted while a sequence is running
  always_ff @(posedge clock_160) begin
    new_q <= new_d;
  end

  assign cfg     = cfg_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign ign     = ign_q;
  assign rst_req = rst_q;

endmodule
